// File: rtl/ivd_flush_sequencer.sv
// ivd_flush_sequencer
// Round-robin arbiter for detector result handshakes. Accepted results go
// into a small first-word-fall-through FIFO for the host, and each accepted
// result opens its channel's flush valve for FLUSH_CYCLES cycles. Only one
// valve may be open at a time because the waste line is shared.
//
// Optional build macro IVD_TIMESTAMP_EN: adds a 16-bit free-running cycle
// counter. Each FIFO entry then records the counter value at its handshake,
// and res_data becomes {timestamp, channel id, reading}.
module ivd_flush_sequencer #(
  parameter int N_CH         = 6,
  parameter int DATA_W       = 8,
  parameter int FLUSH_CYCLES = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH-1:0]          det_valid,
  input  logic [N_CH*DATA_W-1:0]   det_data,
  output logic [N_CH-1:0]          det_ready,
  output logic                     res_valid,
`ifdef IVD_TIMESTAMP_EN
  output logic [16+3+DATA_W-1:0]   res_data,
`else
  output logic [3+DATA_W-1:0]      res_data,
`endif
  input  logic                     res_ready,
  output logic [N_CH-1:0]          flush_valve,
  output logic                     busy
);

`ifdef IVD_TIMESTAMP_EN
  localparam int ENTRY_W = 16 + 3 + DATA_W;
`else
  localparam int ENTRY_W = 3 + DATA_W;
`endif
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int FC_W  = $clog2(FLUSH_CYCLES + 1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_FLUSH = 1'b1;

  logic [0:0]        state_reg;
  logic [2:0]        last_reg;
  logic [FC_W-1:0]   fcnt_reg;
  logic [N_CH-1:0]   valve_reg;

  logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [PTR_W-1:0]   rd_ptr_reg;
  logic [PTR_W:0]     count_reg;

  logic               grant_found;
  logic [2:0]         grant_idx;
  int                 idx;
  logic               fifo_full;
  logic               push;
  logic               pop;
  logic [DATA_W-1:0]  grant_data;
  logic [ENTRY_W-1:0] push_entry;

  // Round-robin search: first requesting channel after the last granted one.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = 3'd0;
    idx         = 0;
    for (int i = 1; i <= N_CH; i++) begin
      idx = (int'(last_reg) + i) % N_CH;
      if (!grant_found && det_valid[idx]) begin
        grant_found = 1'b1;
        grant_idx   = 3'(idx);
      end
    end
  end

  // A full FIFO blocks the grant even if the host pops in the same cycle,
  // so the detector simply keeps holding its result.
  assign fifo_full  = (count_reg == (PTR_W+1)'(FIFO_DEPTH));
  assign push       = !rst && (state_reg == S_IDLE) && grant_found && !fifo_full;
  assign pop        = (count_reg != '0) && res_ready;
  assign grant_data = det_data[int'(grant_idx)*DATA_W +: DATA_W];

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ready
      assign det_ready[gi] = push && (grant_idx == 3'(gi));
    end
  endgenerate

`ifdef IVD_TIMESTAMP_EN
  logic [15:0] ts_reg;

  // Free-running cycle counter; wraps naturally from 0xFFFF to 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ts_reg <= 16'd0;
    else     ts_reg <= ts_reg + 16'd1;
  end

  assign push_entry = {ts_reg, grant_idx, grant_data};
`else
  assign push_entry = {grant_idx, grant_data};
`endif

  // FIFO storage: written on handshake, contents need no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= push_entry;
  end

  // FIFO pointers and occupancy; pointers wrap because depth is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign res_valid = (count_reg != '0);
  assign res_data  = res_valid ? mem[rd_ptr_reg] : '0;

  // Flush FSM: open the granted channel's valve for exactly FLUSH_CYCLES cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
      last_reg  <= 3'(N_CH - 1);
      fcnt_reg  <= '0;
      valve_reg <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (push) begin
            state_reg <= S_FLUSH;
            last_reg  <= grant_idx;
            fcnt_reg  <= '0;
            valve_reg <= det_ready;
          end
        end
        default: begin
          if (fcnt_reg == FC_W'(FLUSH_CYCLES - 1)) begin
            state_reg <= S_IDLE;
            valve_reg <= '0;
          end else begin
            fcnt_reg <= fcnt_reg + 1'b1;
          end
        end
      endcase
    end
  end

  assign flush_valve = valve_reg;
  assign busy        = (state_reg == S_FLUSH);

endmodule

// File: tb/tb_ivd_flush_sequencer.sv
// Testbench for ivd_flush_sequencer: table-driven round-robin grants plus
// hand-written sequences; FIFO results are checked through a scoreboard queue.
module tb_ivd_flush_sequencer;
  localparam int N_CH = 6;
  localparam int DW   = 8;
  localparam int FC   = 16;
`ifdef IVD_TIMESTAMP_EN
  localparam int RES_W = 16 + 3 + DW;
`else
  localparam int RES_W = 3 + DW;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N_CH-1:0]      det_valid;
  logic [N_CH*DW-1:0]   det_data;
  logic [N_CH-1:0]      det_ready;
  logic                 res_valid;
  logic [RES_W-1:0]     res_data;
  logic                 res_ready;
  logic [N_CH-1:0]      flush_valve;
  logic                 busy;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  logic [RES_W-1:0] sb_q[$];

  ivd_flush_sequencer #(.N_CH(N_CH), .DATA_W(DW), .FLUSH_CYCLES(FC), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .det_valid(det_valid), .det_data(det_data),
    .det_ready(det_ready), .res_valid(res_valid), .res_data(res_data),
    .res_ready(res_ready), .flush_valve(flush_valve), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef IVD_TIMESTAMP_EN
  logic [15:0] ts_model;
  always @(posedge clk or posedge rst) begin
    if (rst) ts_model <= 16'd0;
    else     ts_model <= ts_model + 16'd1;
  end
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [RES_W-1:0] make_entry(input int ch);
    logic [DW-1:0] d;
    d = det_data[ch*DW +: DW];
`ifdef IVD_TIMESTAMP_EN
    return {ts_model, 3'(ch), d};
`else
    return {3'(ch), d};
`endif
  endfunction

  // Scoreboard pop on every host transfer, plus per-cycle exclusivity check.
  always @(negedge clk) begin
    if (!rst) begin
      logic ok;
      logic [RES_W-1:0] e;
      ok = $onehot0(flush_valve) && $onehot0(det_ready) && !(busy && det_ready != '0);
      chk("valve_ready_exclusive", {31'd0, ok}, 32'd1);
      if (res_valid && res_ready) begin
        if (sb_q.size() == 0) begin
          n_total++;
          $display("FAIL sb_pop: res_data=%0h popped with no entry expected", res_data);
        end else begin
          e = sb_q.pop_front();
          chk("res_data", 32'(res_data), 32'(e));
          $display("pop res_data=%0h expected=%0h", res_data, e);
        end
      end
    end
  end

  // Drive mask, wait (bounded) for a grant, check it, record the handshake.
  task automatic grant(input logic [N_CH-1:0] mask, input int exp_ch, output int hs_cyc);
    bit got;
    got = 1'b0;
    det_data  = {$urandom, $urandom};
    det_valid = mask;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (det_ready != '0) got = 1'b1;
    end
    chk($sformatf("grant_ch%0d", exp_ch), 32'(det_ready), 32'(1 << exp_ch));
    if (got) sb_q.push_back(make_entry(exp_ch));
    $display("grant mask=%b det_ready=%b expected_ch=%0d cycle=%0d", mask, det_ready, exp_ch, cyc);
    hs_cyc = cyc;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    det_valid = '0;
    sb_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic [N_CH-1:0] mask;
    int              ch;
  } vec_t;
  vec_t tbl[8];

  initial begin
    int hs, prev, cnt;
    tbl[0] = '{6'b111111, 3};
    tbl[1] = '{6'b111111, 4};
    tbl[2] = '{6'b111111, 5};
    tbl[3] = '{6'b111111, 0};
    tbl[4] = '{6'b000011, 1};
    tbl[5] = '{6'b100001, 5};
    tbl[6] = '{6'b100001, 0};
    tbl[7] = '{6'b010000, 4};

    // Reset state with requests pending: nothing may be granted.
    rst = 1'b1; det_valid = 6'b111111; det_data = '0; res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_det_ready", 32'(det_ready), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_data", 32'(res_data), 32'd0);
    chk("rst_flush_valve", 32'(flush_valve), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    det_valid = '0;
    @(posedge clk); #1;
    rst = 1'b0;

    // Single channel 2, reading A5: valve opens for exactly FC cycles.
    res_ready = 1'b1;
    det_data = {$urandom, $urandom};
    det_data[2*DW +: DW] = 8'hA5;
    det_valid = 6'b000100;
    @(negedge clk);
    chk("single_det_ready", 32'(det_ready), 32'b000100);
    if (det_ready != '0) sb_q.push_back(make_entry(2));
    @(posedge clk); #1;
    det_valid = '0;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (flush_valve == 6'b000100 && busy) cnt++;
      else if (cnt > 0) break;
    end
    chk("valve_open_cycles", 32'(cnt), 32'(FC));
    chk("valve_closed", 32'(flush_valve), 32'd0);
    chk("busy_cleared", 32'(busy), 32'd0);
    @(posedge clk); #1;

    // Table-driven round-robin grants.
    for (int v = 0; v < 8; v++) grant(tbl[v].mask, tbl[v].ch, hs);
    det_valid = '0;

    // Held requests from reset: order 0..5,0 spaced FC+1 cycles.
    do_reset();
    grant(6'b111111, 0, prev);
    for (int k = 1; k <= 6; k++) begin
      grant(6'b111111, k % N_CH, hs);
      chk("hs_spacing", 32'(hs - prev), 32'(FC + 1));
      prev = hs;
    end
    det_valid = '0;

    // FIFO full: four results held, then a single pop frees one slot.
    do_reset();
    res_ready = 1'b0;
    for (int k = 0; k < 4; k++) grant(6'b111111, k, hs);
    repeat (20) @(negedge clk);
    chk("full_no_grant", 32'(det_ready), 32'd0);
    chk("full_valve_closed", 32'(flush_valve), 32'd0);
    chk("full_idle", 32'(busy), 32'd0);
    chk("full_res_valid", 32'(res_valid), 32'd1);
    @(posedge clk); #1;
    res_ready = 1'b1;
    @(negedge clk);
    chk("full_pop_no_grant", 32'(det_ready), 32'd0);
    @(posedge clk); #1;
    res_ready = 1'b0;
    grant(6'b111111, 4, hs);
    det_valid = '0;
    res_ready = 1'b1;
    repeat (8) @(negedge clk);
    chk("drained_res_valid", 32'(res_valid), 32'd0);
    chk("drained_sb_empty", 32'(sb_q.size()), 32'd0);
    @(posedge clk); #1;

    // Simultaneous push and pop with one entry held.
    res_ready = 1'b0;
    grant(6'b000001, 0, hs);
    det_valid = '0;
    repeat (FC + 2) @(posedge clk);
    #1;
    res_ready = 1'b1;
    grant(6'b000010, 1, hs);
    det_valid = '0;
    res_ready = 1'b0;
    @(negedge clk);
    chk("pushpop_res_valid", 32'(res_valid), 32'd1);
    chk("pushpop_head", 32'(res_data), (sb_q.size() > 0) ? 32'(sb_q[0]) : 32'hFFFF_FFFF);
    chk("pushpop_sb_size", 32'(sb_q.size()), 32'd1);
    @(posedge clk); #1;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    @(negedge clk);
    chk("pushpop_empty", 32'(res_valid), 32'd0);
    @(posedge clk); #1;

    // Reset during flush cycle 5 of channel 3.
    grant(6'b001000, 3, hs);
    det_valid = '0;
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_valve", 32'(flush_valve), 32'd0);
    chk("midrst_res_valid", 32'(res_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    sb_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    res_ready = 1'b1;
    grant(6'b101000, 3, hs);
    det_valid = '0;
    repeat (FC + 4) @(posedge clk);
    #1;
    chk("final_sb_empty", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
